// File: rtl/led_pwm_fade_pkg.sv
// Shared types for the LED PWM fade block: per-channel state encoding and the
// duty/target classifier used by the channel state machine.
package led_pwm_fade_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_UP   = 2'd1,
        ST_ON   = 2'd2,
        ST_DOWN = 2'd3
    } led_state_t;

    // The state is a pure function of where duty sits relative to its target.
    function automatic led_state_t led_classify(input logic [31:0] duty,
                                                input logic [31:0] target);
        led_state_t st;
        if (duty < target) begin
            st = ST_UP;
        end else if (duty > target) begin
            st = ST_DOWN;
        end else if (duty == 32'd0) begin
            st = ST_OFF;
        end else begin
            st = ST_ON;
        end
        return st;
    endfunction

endpackage

// File: rtl/led_pwm_chan.sv
// Purpose: one LED channel - duty register, fade state machine, PWM compare, output/busy flops.
// Latency: o_led follows i_pwm_cnt by one clock; duty changes only on i_period_end.
// Backpressure: none; free-running, consumes inputs every cycle.
module led_pwm_chan
    import led_pwm_fade_pkg::*;
#(
    parameter int P_PWM_BITS = 8,
    parameter int P_IN_ON    = 1,
    parameter int P_LED_ON   = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req,
    input  logic [P_PWM_BITS-1:0] i_max_duty,
    input  logic                  i_fade_en,
    input  logic [P_PWM_BITS-1:0] i_pwm_cnt,
    input  logic                  i_period_end,
    input  logic                  i_fade_tick,
    output logic                  o_led,
    output logic                  o_busy
);

    localparam logic IN_LVL = (P_IN_ON != 0);
    localparam logic ON_LVL = (P_LED_ON != 0);

    logic [P_PWM_BITS-1:0] target;
    logic [P_PWM_BITS-1:0] duty;
    logic [P_PWM_BITS-1:0] duty_nxt;
    logic                  lit;
    led_state_t            state;

    // Stepping only while strictly below/above target keeps +1/-1 inside 0..2^B-1.
    always_comb begin
        target   = (i_req == IN_LVL) ? i_max_duty : '0;
        duty_nxt = duty;
        if (!i_fade_en) begin
            duty_nxt = target;
        end else if (i_fade_tick) begin
            if (duty < target) begin
                duty_nxt = duty + 1'b1;
            end else if (duty > target) begin
                duty_nxt = duty - 1'b1;
            end
        end
    end

    assign lit = (state != ST_OFF) && (i_pwm_cnt < duty);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            duty   <= '0;
            state  <= ST_OFF;
            o_led  <= ~ON_LVL;
            o_busy <= 1'b0;
        end else begin
            if (i_period_end) begin
                duty  <= duty_nxt;
                state <= led_classify(32'(duty_nxt), 32'(target));
            end
            o_led  <= lit ? ON_LVL : ~ON_LVL;
            o_busy <= (duty != target);
        end
    end

endmodule

// File: rtl/led_pwm_fade.sv
// Purpose: shared PWM timebase (prescaler, pwm counter, fade divider) driving P_LED_NUM channels.
// Latency: one clock from pwm counter to o_led; duty updates land on PWM period boundaries.
// Backpressure: none; free-running.
module led_pwm_fade
    import led_pwm_fade_pkg::*;
#(
    parameter int P_LED_NUM           = 2,
    parameter int P_PWM_BITS          = 8,
    parameter int P_PWM_DIV           = 39,
    parameter int P_FADE_STEP_PERIODS = 4,
    parameter int P_IN_ON             = 1,
    parameter int P_LED_ON            = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [P_LED_NUM-1:0]  i_led_req,
    input  logic [P_PWM_BITS-1:0] i_max_duty,
    input  logic                  i_fade_en,
    output logic [P_LED_NUM-1:0]  o_led,
    output logic [P_LED_NUM-1:0]  o_busy
);

    localparam int PW = (P_PWM_DIV > 1) ? $clog2(P_PWM_DIV) : 1;
    localparam int FW = (P_FADE_STEP_PERIODS > 1) ? $clog2(P_FADE_STEP_PERIODS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(P_PWM_DIV - 1);
    localparam logic [FW-1:0] FADE_LAST  = FW'(P_FADE_STEP_PERIODS - 1);

    logic [PW-1:0]         presc;
    logic [P_PWM_BITS-1:0] pwm_cnt;
    logic [FW-1:0]         fade_cnt;
    logic                  step_tick;
    logic                  period_end;
    logic                  fade_tick;

    assign step_tick  = (presc == PRESC_LAST);
    assign period_end = step_tick && (pwm_cnt == '1);
    assign fade_tick  = period_end && (fade_cnt == FADE_LAST);

    // pwm_cnt wraps naturally at 2^B; the fade divider only moves on period ends.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            presc    <= '0;
            pwm_cnt  <= '0;
            fade_cnt <= '0;
        end else begin
            presc <= step_tick ? '0 : presc + 1'b1;
            if (step_tick) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
            if (period_end) begin
                fade_cnt <= fade_tick ? '0 : fade_cnt + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < P_LED_NUM; g++) begin : g_chan
        led_pwm_chan #(
            .P_PWM_BITS (P_PWM_BITS),
            .P_IN_ON    (P_IN_ON),
            .P_LED_ON   (P_LED_ON)
        ) u_chan (
            .i_clk        (i_clk),
            .i_rst_n      (i_rst_n),
            .i_req        (i_led_req[g]),
            .i_max_duty   (i_max_duty),
            .i_fade_en    (i_fade_en),
            .i_pwm_cnt    (pwm_cnt),
            .i_period_end (period_end),
            .i_fade_tick  (fade_tick),
            .o_led        (o_led[g]),
            .o_busy       (o_busy[g])
        );
    end

endmodule

// File: tb/tb_led_pwm_fade.sv
// Bench for led_pwm_fade with B=4, DIV=2, one PWM period per fade step (32 clk per period).
module tb_led_pwm_fade;

    localparam int NLED   = 2;
    localparam int B      = 4;
    localparam int DIV    = 2;
    localparam int STEPS  = 1 << B;
    localparam int PERIOD = DIV * STEPS;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] led_req;
    logic [3:0] max_duty;
    logic       fade_en;
    logic [1:0] led;
    logic [1:0] busy;

    always #5 clk = ~clk;

    led_pwm_fade #(
        .P_LED_NUM           (NLED),
        .P_PWM_BITS          (B),
        .P_PWM_DIV           (DIV),
        .P_FADE_STEP_PERIODS (1),
        .P_IN_ON             (1),
        .P_LED_ON            (1)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_led_req  (led_req),
        .i_max_duty (max_duty),
        .i_fade_en  (fade_en),
        .o_led      (led),
        .o_busy     (busy)
    );

    int vectors     = 0;
    int miscompares = 0;
    int n           = 0;
    int mdl_duty[NLED];
    int hi;

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge with inputs already set; models the coming clock edge from
    // the elapsed-cycle count, then checks the outputs at the following negedge.
    task automatic cycle();
        int         pc;
        bit         pe;
        int         tgt;
        logic [1:0] exp_led;
        logic [1:0] exp_busy;
        pc = (n / DIV) % STEPS;
        pe = (n % PERIOD) == PERIOD - 1;
        for (int c = 0; c < NLED; c++) begin
            tgt         = led_req[c] ? int'(max_duty) : 0;
            exp_led[c]  = pc < mdl_duty[c];
            exp_busy[c] = mdl_duty[c] != tgt;
            if (pe) begin
                if (!fade_en)              mdl_duty[c] = tgt;
                else if (mdl_duty[c] < tgt) mdl_duty[c] = mdl_duty[c] + 1;
                else if (mdl_duty[c] > tgt) mdl_duty[c] = mdl_duty[c] - 1;
            end
        end
        @(posedge clk);
        n++;
        @(negedge clk);
        chk("led", int'(led), int'(exp_led));
        chk("busy", int'(busy), int'(exp_busy));
    endtask

    task automatic run(input int cycles);
        for (int k = 0; k < cycles; k++) cycle();
    endtask

    // Count lit clocks of channel 0 over one full PWM period.
    task automatic measure_hi();
        hi = 0;
        for (int k = 0; k < PERIOD; k++) begin
            cycle();
            hi += int'(led[0]);
        end
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        n     = 0;
        for (int c = 0; c < NLED; c++) mdl_duty[c] = 0;
    endtask

    initial begin
        int guard;
        rst_n    = 1'b0;
        led_req  = 2'b11;
        max_duty = 4'd15;
        fade_en  = 1'b0;
        for (int c = 0; c < NLED; c++) mdl_duty[c] = 0;

        // Held in reset with both requests active: everything dark.
        repeat (3) @(negedge clk);
        chk("rst_led", int'(led), 0);
        chk("rst_busy", int'(busy), 0);

        // Jump mode, max 8, LED0 only: 16 of 32 clocks lit, LED1 dark.
        led_req  = 2'b01;
        max_duty = 4'd8;
        release_reset();
        run(PERIOD + 8);
        measure_hi();
        chk("jump_hi_time", hi, 16);
        chk("jump_led1_dark", int'(led[1]), 0);

        // Glitch check: max changed mid-period; the model checks the current period is untouched.
        run(10);
        max_duty = 4'd2;
        run(2 * PERIOD);
        measure_hi();
        chk("retarget_hi_time", hi, 4);

        // Fade up from dark to 15.
        led_req = 2'b00;
        run(PERIOD);
        fade_en  = 1'b1;
        max_duty = 4'd15;
        led_req  = 2'b01;
        run(16 * PERIOD);
        chk("fade_up_busy_done", int'(busy[0]), 0);
        measure_hi();
        chk("full_hi_time", hi, 30);

        // Fresh ramp, dropped at duty 5: ramps back down to OFF.
        fade_en = 1'b0;
        led_req = 2'b00;
        run(PERIOD);
        fade_en = 1'b1;
        led_req = 2'b01;
        guard = 0;
        while (mdl_duty[0] != 5 && guard < 12 * PERIOD) begin
            cycle();
            guard++;
        end
        chk("reach_duty5", mdl_duty[0], 5);
        led_req = 2'b00;
        run(7 * PERIOD);
        chk("fade_down_busy", int'(busy), 0);
        measure_hi();
        chk("fade_down_hi_time", hi, 0);

        // ON at 15, ceiling lowered to 4, then to 0 with request held.
        led_req  = 2'b11;
        max_duty = 4'd15;
        run(17 * PERIOD);
        max_duty = 4'd4;
        run(13 * PERIOD);
        chk("lowered_busy", int'(busy), 0);
        measure_hi();
        chk("lowered_hi_time", hi, 8);
        max_duty = 4'd0;
        run(6 * PERIOD);
        measure_hi();
        chk("max0_hi_time", hi, 0);
        chk("max0_busy", int'(busy), 0);

        // Randomized traffic with one asynchronous reset landing while an LED is lit.
        for (int k = 0; k < 6000; k++) begin
            if ($urandom_range(0, 149) == 0) led_req  = 2'($urandom);
            if ($urandom_range(0, 299) == 0) max_duty = 4'($urandom);
            if ($urandom_range(0, 499) == 0) fade_en  = 1'($urandom);
            cycle();
            if (k == 3000) begin
                led_req  = 2'b11;
                max_duty = 4'd12;
                guard = 0;
                while (led == 2'b00 && guard < 40 * PERIOD) begin
                    cycle();
                    guard++;
                end
                chk("lit_before_reset", int'(led != 2'b00), 1);
                #2;
                rst_n = 1'b0;
                #1;
                chk("async_rst_led", int'(led), 0);
                chk("async_rst_busy", int'(busy), 0);
                repeat (2) @(negedge clk);
                chk("held_rst_led", int'(led), 0);
                release_reset();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
